// File: rtl/corr_packetizer.sv
// corr_packetizer: snapshots the correlator accumulators at the end of an
// integration period and streams header + payload + footer as a byte stream
// over a valid/ready handshake. BINARY=0 emits one ASCII hex char per nibble
// plus a trailing CR; BINARY=1 emits raw bytes.
// Optional: define CORR_PACKETIZER_CHECKSUM_EN to put the XOR of all snapshot
// words in footer[31:0]; otherwise that field is the constant 32'hA5A5A5A5.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start with enable high
// SNAP    | snapshot held, clear_acc pulsed, first header unit loaded
// HEADER  | emitting {7'b0, overrun, timestamp}
// PAYLOAD | emitting the shadow register, top word first
// FOOTER  | emitting {sequence, checksum}
// TERM    | emitting CR (ASCII mode only)
module corr_packetizer #(
  parameter int RESOLUTION = 24,
  parameter int NUM_WORDS  = 16,
  parameter int BINARY     = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            start,
  input  logic [NUM_WORDS*RESOLUTION-1:0] pulses,
  output logic                            clear_acc,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            busy,
  output logic                            overrun
);

  localparam int PAY_W     = NUM_WORDS * RESOLUTION;
  localparam int FRAME_W   = 128 + PAY_W;
  localparam int UNIT_W    = (BINARY != 0) ? 8 : 4;
  localparam int UNITS     = FRAME_W / UNIT_W;
  localparam int HDR_UNITS = 64 / UNIT_W;
  localparam int PAY_END   = HDR_UNITS + PAY_W / UNIT_W;
  localparam int IDX_W     = $clog2(UNITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_HEADER, S_PAYLOAD, S_FOOTER, S_TERM
  } state_t;

  state_t             state, next_state;
  logic [55:0]        ts_cnt;
  logic [31:0]        seq_num;
  logic [PAY_W-1:0]   shadow;
  logic [63:0]        hdr_reg;
  logic [31:0]        chk_val;
  logic [IDX_W-1:0]   rem_cnt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [FRAME_W-1:0] frame;
  int                 shift_amt;
  logic [3:0]         nib;
  logic [7:0]         unit_byte;
  logic               xfer;
  logic               last_unit;
  logic               accept;
  logic               final_xfer;

  // rem_cnt counts down the units still to follow the one on the bus
  assign xfer       = tx_valid && tx_ready;
  assign last_unit  = (rem_cnt == '0);
  assign idx        = IDX_W'(UNITS - 1) - rem_cnt;
  assign accept     = (state == S_IDLE) && start && enable;
  assign final_xfer = xfer && ((state == S_TERM) ||
                               ((BINARY != 0) && (state == S_FOOTER) && last_unit));
  assign frame      = {hdr_reg, shadow, seq_num, chk_val};

`ifdef CORR_PACKETIZER_CHECKSUM_EN
  localparam int EXT_W = (RESOLUTION > 32) ? RESOLUTION : 32;
  logic [31:0]      chk_reg;
  logic [31:0]      chk_comb;
  logic [EXT_W-1:0] word_ext;

  // XOR of all snapshot words, each zero-extended or truncated to 32 bits
  always_comb begin
    chk_comb = '0;
    word_ext = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      word_ext = '0;
      word_ext[RESOLUTION-1:0] = shadow[i*RESOLUTION +: RESOLUTION];
      chk_comb = chk_comb ^ word_ext[31:0];
    end
  end

  // checksum registered in SNAP, well before the footer needs it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                chk_reg <= '0;
    else if (state == S_SNAP)  chk_reg <= chk_comb;
  end

  assign chk_val = chk_reg;
`else
  assign chk_val = 32'hA5A5A5A5;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // next-state logic; unit index marks the section boundaries
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (accept) next_state = S_SNAP;
      S_SNAP:    next_state = S_HEADER;
      S_HEADER:  if (xfer && (idx == IDX_W'(HDR_UNITS - 1))) next_state = S_PAYLOAD;
      S_PAYLOAD: if (xfer && (idx == IDX_W'(PAY_END - 1)))   next_state = S_FOOTER;
      S_FOOTER:  if (xfer && last_unit) next_state = (BINARY != 0) ? S_IDLE : S_TERM;
      S_TERM:    if (xfer) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy      = (state != S_IDLE);
    clear_acc = (state == S_SNAP);
    tx_valid  = (state == S_HEADER) || (state == S_PAYLOAD) ||
                (state == S_FOOTER) || (state == S_TERM);
  end

  // selects the next unit of the frame, MSB first, and encodes it
  always_comb begin
    sel_idx   = (state == S_SNAP) ? '0 : idx + IDX_W'(1);
    shift_amt = FRAME_W - UNIT_W * (int'(sel_idx) + 1);
    nib       = 4'(frame >> shift_amt);
    if (BINARY != 0)       unit_byte = 8'(frame >> shift_amt);
    else if (nib < 4'd10)  unit_byte = 8'h30 + {4'h0, nib};
    else                   unit_byte = 8'h37 + {4'h0, nib};
  end

  // free-running timestamp, gated by enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ts_cnt <= '0;
    else if (enable) ts_cnt <= ts_cnt + 56'd1;
  end

  // sticky overrun on any enabled start that finds the block busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      overrun <= 1'b0;
    else if (start && enable && (state != S_IDLE))   overrun <= 1'b1;
  end

  // snapshot of accumulators and header fields at start acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      hdr_reg <= '0;
    end else if (accept) begin
      shadow  <= pulses;
      hdr_reg <= {7'b0, overrun, ts_cnt};
    end
  end

  // packet sequence number advances on the last byte of each packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          seq_num <= '0;
    else if (final_xfer) seq_num <= seq_num + 32'd1;
  end

  // output byte register and unit down-counter; data holds while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_cnt <= '0;
      tx_data <= 8'h00;
    end else if (state == S_SNAP) begin
      rem_cnt <= IDX_W'(UNITS - 1);
      tx_data <= unit_byte;
    end else if (xfer && (state != S_TERM)) begin
      if (!last_unit) begin
        rem_cnt <= rem_cnt - IDX_W'(1);
        tx_data <= unit_byte;
      end else if (BINARY == 0) begin
        tx_data <= 8'h0D;
      end
    end
  end

endmodule

// File: tb/tb_corr_packetizer.sv
// Bench for corr_packetizer: an ASCII instance and a binary instance share
// all inputs. A packet-level scoreboard predicts every emitted byte, busy,
// overrun and clear_acc from the packet format rules; directed sequences and
// a small vector table cover the listed corner cases, then random traffic.
module tb_corr_packetizer;

  localparam int RES = 8;
  localparam int NW  = 2;

  logic             clk = 1'b0;
  logic             rst_n, enable, start, tx_ready;
  logic [15:0]      pulses;
  logic [1:0]       clr, txv, busy, ovr;
  logic [1:0][7:0]  txd;

  always #5 clk = ~clk;

  corr_packetizer #(.RESOLUTION(RES), .NUM_WORDS(NW), .BINARY(0)) u_asc (
    .clk(clk), .reset(rst_n), .enable(enable), .start(start), .pulses(pulses),
    .clear_acc(clr[0]), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_ready),
    .busy(busy[0]), .overrun(ovr[0]));

  corr_packetizer #(.RESOLUTION(RES), .NUM_WORDS(NW), .BINARY(1)) u_bin (
    .clk(clk), .reset(rst_n), .enable(enable), .start(start), .pulses(pulses),
    .clear_acc(clr[1]), .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_ready),
    .busy(busy[1]), .overrun(ovr[1]));

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  pkt [2][64];
  int          len_m [2];
  int          ptr_m [2];
  logic [31:0] seq_m [2];
  logic        ovr_m [2];
  logic        snap_m [2];
  logic        stall_m [2];
  logic [7:0]  stall_d [2];
  logic [55:0] ts_m;
  logic [7:0]  cap0 [$];
  logic [7:0]  cap1 [$];
  logic [7:0]  a0 [64];
  logic [7:0]  a1 [64];
  logic [7:0]  mk [64];
  int          mk_len;
  int          rdy_mode = 0;
  int          cyc = 0;

  typedef struct {
    logic [15:0] pl;
    logic [31:0] asc;
    logic [15:0] bin;
    logic [7:0]  x;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexchar(input logic [3:0] n);
    if (n < 4'd10) return 8'(n) + 8'd48;
    return 8'(n - 4'd10) + "A";
  endfunction

  function automatic logic [31:0] chk_model(input logic [15:0] p);
`ifdef CORR_PACKETIZER_CHECKSUM_EN
    return {24'h0, p[15:8] ^ p[7:0]};
`else
    return 32'hA5A5A5A5;
`endif
  endfunction

  // expected byte stream of one packet into mk/mk_len
  task automatic make_pkt(input int bin, input logic ov, input logic [55:0] ts,
                          input logic [15:0] p, input logic [31:0] sq);
    logic [143:0] f;
    f = {7'b0, ov, ts, p, sq, chk_model(p)};
    if (bin != 0) begin
      for (int i = 0; i < 18; i++) mk[i] = f[143-8*i -: 8];
      mk_len = 18;
    end else begin
      for (int i = 0; i < 36; i++) mk[i] = hexchar(f[143-4*i -: 4]);
      mk[36] = 8'h0D;
      mk_len = 37;
    end
  endtask

  // scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        len_m[d] = 0; ptr_m[d] = 0; seq_m[d] = 0; ovr_m[d] = 0;
        snap_m[d] = 0; stall_m[d] = 0; stall_d[d] = 8'h00;
      end else begin
        logic pre;
        logic acc;
        pre = (len_m[d] - ptr_m[d]) != 0;
        acc = 1'b0;
        check($sformatf("busy[%0d]", d), busy[d], pre);
        check($sformatf("overrun[%0d]", d), ovr[d], ovr_m[d]);
        check($sformatf("clear_acc[%0d]", d), clr[d], snap_m[d]);
        check($sformatf("tx_valid[%0d]", d), txv[d], pre && !snap_m[d]);
        if (stall_m[d]) check($sformatf("hold_data[%0d]", d), txd[d], stall_d[d]);
        if (txv[d] && tx_ready) begin
          check($sformatf("byte_in_packet[%0d]", d), ptr_m[d] < len_m[d], 1);
          if (ptr_m[d] < len_m[d]) begin
            check($sformatf("byte%0d[%0d]", ptr_m[d], d), txd[d], pkt[d][ptr_m[d]]);
            ptr_m[d]++;
            if (ptr_m[d] == len_m[d]) seq_m[d] = seq_m[d] + 1;
          end
          if (d == 0) cap0.push_back(txd[0]); else cap1.push_back(txd[1]);
        end
        if (start && enable) begin
          if (pre) ovr_m[d] = 1'b1;
          else begin
            make_pkt(d, ovr_m[d], ts_m, pulses, seq_m[d]);
            for (int i = 0; i < 64; i++) pkt[d][i] = mk[i];
            len_m[d] = mk_len;
            ptr_m[d] = 0;
            acc = 1'b1;
          end
        end
        stall_m[d] = txv[d] && !tx_ready;
        stall_d[d] = txd[d];
        snap_m[d]  = acc;
      end
    end
    if (!rst_n)      ts_m = '0;
    else if (enable) ts_m = ts_m + 56'd1;
  end

  // sink ready pattern
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ts(input logic [55:0] v);
    int k = 0;
    while (ts_m != v && k < 200) begin tick(); k++; end
    check("ts_reached", k < 200, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy != 2'b00 && k < 3000) begin tick(); k++; end
    check("idle_in_time", k < 3000, 1);
  endtask

  task automatic snap_caps();
    for (int i = 0; i < 64; i++) begin a0[i] = 8'h00; a1[i] = 8'h00; end
    foreach (cap0[i]) if (i < 64) a0[i] = cap0[i];
    foreach (cap1[i]) if (i < 64) a1[i] = cap1[i];
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
  endtask

  initial begin
    int k;
    tbl[0] = '{16'h12AB, 32'h31324142, 16'h12AB, 8'hB9};
    tbl[1] = '{16'hFFFF, 32'h46464646, 16'hFFFF, 8'h00};
    tbl[2] = '{16'h0000, 32'h30303030, 16'h0000, 8'h00};
    tbl[3] = '{16'h09A5, 32'h30394135, 16'h09A5, 8'hAC};
    tbl[4] = '{16'h7E3C, 32'h37453343, 16'h7E3C, 8'h42};

    rst_n = 1'b0; enable = 1'b0; start = 1'b0; pulses = 16'h0000;
    tick(); tick();
    check("rst_tx_data", {txd[1], txd[0]}, 16'h0000);
    check("rst_tx_valid", txv, 2'b00);
    check("rst_busy", busy, 2'b00);
    check("rst_overrun", ovr, 2'b00);
    check("rst_clear_acc", clr, 2'b00);

    // basic packet, ready always high
    rst_n = 1'b1; enable = 1'b1; pulses = 16'h12AB;
    wait_ts(56'h10);
    clear_caps();
    start_pulse();
    check("snap_clear_acc", clr, 2'b11);
    check("snap_valid_low", txv, 2'b00);
    tick();
    check("post_snap_clear_acc", clr, 2'b00);
    check("first_valid", txv, 2'b11);
    wait_idle();
    snap_caps();
    check("asc_len", cap0.size(), 37);
    check("bin_len", cap1.size(), 18);
    check("asc_first", a0[0], 8'h30);
    check("asc_ts_chars", {a0[14], a0[15]}, 16'h3130);
    check("asc_payload", {a0[16], a0[17], a0[18], a0[19]}, 32'h31324142);
`ifdef CORR_PACKETIZER_CHECKSUM_EN
    check("asc_footer_tail", {a0[34], a0[35]}, 16'h4239);
    check("bin_footer_chk", a1[17], 8'hB9);
`else
    check("asc_footer_tail", {a0[34], a0[35]}, 16'h4135);
    check("bin_footer_chk", a1[17], 8'hA5);
`endif
    check("asc_cr", a0[36], 8'h0D);
    check("bin_hdr_ts", {a1[6], a1[7]}, 16'h0010);
    check("bin_payload", {a1[8], a1[9]}, 16'h12AB);

    // 1-of-3 ready, pulses change mid-packet, second start while busy
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rdy_mode = 1; pulses = 16'h12AB;
    wait_ts(56'h10);
    clear_caps();
    start_pulse();
    tick(); tick();
    pulses = 16'hFFFF;
    tick();
    start_pulse();
    check("overrun_set", ovr, 2'b11);
    wait_idle();
    snap_caps();
    check("single_packet_asc", cap0.size(), 37);
    check("single_packet_bin", cap1.size(), 18);
    make_pkt(0, 1'b0, 56'h10, 16'h12AB, 32'd0);
    for (int i = 0; i < 37; i++) check($sformatf("slow_ready_byte%0d", i), a0[i], mk[i]);

    // header carries overrun, sequence advanced to 1
    rdy_mode = 0; pulses = 16'h12AB;
    clear_caps();
    start_pulse();
    wait_idle();
    snap_caps();
    check("hdr_overrun_asc", {a0[0], a0[1]}, 16'h3031);
    check("hdr_overrun_bin", a1[0], 8'h01);
    check("seq_one_asc", {a0[24], a0[25], a0[26], a0[27]}, 32'h30303031);
    check("seq_one_bin", {a1[10], a1[11], a1[12], a1[13]}, 32'h00000001);

    // reset after the fifth byte aborts the packet
    clear_caps();
    start_pulse();
    k = 0;
    while (cap0.size() < 5 && k < 100) begin tick(); k++; end
    check("five_bytes_seen", cap0.size() >= 5, 1);
    rst_n = 1'b0;
    #1;
    check("reset_valid_drop", txv, 2'b00);
    check("reset_busy_drop", busy, 2'b00);
    tick(); tick();
    rst_n = 1'b1; pulses = 16'h5A5A;
    clear_caps();
    wait_ts(56'h5);
    start_pulse();
    wait_idle();
    snap_caps();
    check("post_reset_len", cap0.size(), 37);
    check("post_reset_ts", {a0[13], a0[14], a0[15]}, 24'h303035);
    check("post_reset_ovr", a0[1], 8'h30);
    check("post_reset_seq", {a0[20], a0[21], a0[22], a0[23], a0[24], a0[25], a0[26], a0[27]},
          64'h3030303030303030);

    // start with enable low is ignored without overrun
    enable = 1'b0;
    start_pulse();
    tick();
    check("disabled_start_busy", busy, 2'b00);
    check("disabled_start_ovr", ovr, 2'b00);
    enable = 1'b1;

    // vector table
    for (int v = 0; v < 5; v++) begin
      pulses = tbl[v].pl;
      clear_caps();
      start_pulse();
      wait_idle();
      snap_caps();
      check($sformatf("tbl%0d_asc", v), {a0[16], a0[17], a0[18], a0[19]}, tbl[v].asc);
      check($sformatf("tbl%0d_bin", v), {a1[8], a1[9]}, tbl[v].bin);
`ifdef CORR_PACKETIZER_CHECKSUM_EN
      check($sformatf("tbl%0d_chk", v), {a1[14], a1[15], a1[16], a1[17]}, {24'h0, tbl[v].x});
`else
      check($sformatf("tbl%0d_chk", v), {a1[14], a1[15], a1[16], a1[17]}, 32'hA5A5A5A5);
`endif
    end

    // random traffic against the scoreboard
    for (int r = 0; r < 40; r++) begin
      pulses   = 16'($urandom);
      enable   = ($urandom_range(0, 7) != 0);
      rdy_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 50)) tick();
      start_pulse();
    end
    enable = 1'b1;
    rdy_mode = 0;
    wait_idle();
    tick();
    check("drained_asc", len_m[0] - ptr_m[0], 0);
    check("drained_bin", len_m[1] - ptr_m[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
